vga_timing_gen: RTL

Parametrised VGA raster timing generator, the successor to the fixed 640x480 sync counter. It sits between the pixel-clock strobe generator and the pixel/graphics pipeline on the Nexys A7 100T design. It produces registered sync, data-enable and pixel coordinates for any mode set by parameters, with programmable sync polarity. It also adds line/frame/vblank event pulses and a frame counter for animation logic.

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: registered sync, data enable, pixel
// coordinates, line/frame/vblank event pulses and a completed-frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CW       = 11
) (
    input  logic          CLK100MHZ,
    input  logic          reset,
    input  logic          pix_stb,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic [15:0]   frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_B = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_B = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic          H_POL_L  = (H_POL != 0);
    localparam logic          V_POL_L  = (V_POL != 0);

    logic [CW-1:0] x_r, y_r, x_nxt_s, y_nxt_s;
    logic          h_wrap_s, v_wrap_s;
    logic          hs_nxt_s, vs_nxt_s, de_nxt_s, vblank_nxt_s;
    logic          hs_r, vs_r, de_r;
    logic          line_start_r, frame_start_r, vblank_start_r;
    logic [15:0]   frame_cnt_r;

    // Raster advance: next x/y and wrap flags, only on strobe cycles.
    always_comb begin
        x_nxt_s  = x_r;
        y_nxt_s  = y_r;
        h_wrap_s = 1'b0;
        v_wrap_s = 1'b0;
        if (pix_stb) begin
            if (x_r == H_LAST) begin
                x_nxt_s  = '0;
                h_wrap_s = 1'b1;
                if (y_r == V_LAST) begin
                    y_nxt_s  = '0;
                    v_wrap_s = 1'b1;
                end else begin
                    y_nxt_s = y_r + ONE_C;
                end
            end else begin
                x_nxt_s = x_r + ONE_C;
            end
        end else begin
            x_nxt_s = x_r;
        end
    end

    // Sync/enable/pulse decode from next-state coordinates so registers line up with x/y.
    always_comb begin
        hs_nxt_s     = ((x_nxt_s >= H_SYNC_B) && (x_nxt_s < H_SYNC_E)) ? H_POL_L : ~H_POL_L;
        vs_nxt_s     = ((y_nxt_s >= V_SYNC_B) && (y_nxt_s < V_SYNC_E)) ? V_POL_L : ~V_POL_L;
        de_nxt_s     = (x_nxt_s < H_ACT_C) && (y_nxt_s < V_ACT_C);
        vblank_nxt_s = h_wrap_s && (y_nxt_s == V_ACT_C);
    end

    // Output and state registers; reset has priority and discards a same-cycle strobe.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            x_r            <= '0;
            y_r            <= '0;
            hs_r           <= ~H_POL_L;
            vs_r           <= ~V_POL_L;
            de_r           <= 1'b1;
            line_start_r   <= 1'b0;
            frame_start_r  <= 1'b0;
            vblank_start_r <= 1'b0;
            frame_cnt_r    <= 16'd0;
        end else begin
            x_r            <= x_nxt_s;
            y_r            <= y_nxt_s;
            hs_r           <= hs_nxt_s;
            vs_r           <= vs_nxt_s;
            de_r           <= de_nxt_s;
            line_start_r   <= h_wrap_s;
            frame_start_r  <= h_wrap_s & v_wrap_s;
            vblank_start_r <= vblank_nxt_s;
            if (h_wrap_s && v_wrap_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign x            = x_r;
    assign y            = y_r;
    assign hs           = hs_r;
    assign vs           = vs_r;
    assign de           = de_r;
    assign line_start   = line_start_r;
    assign frame_start  = frame_start_r;
    assign vblank_start = vblank_start_r;
    assign frame_cnt    = frame_cnt_r;

endmodule
